// File: rtl/instruction_decode.sv
// LEGv8 ID stage: decode, 32x64 regfile with write-through, sext imm, registered ID/EX buffer; 1-cycle latency.
// Load-use hazard raises stall_out and loads a bubble; flush/if_valid=0 also load a bubble; flush masks stall_out.
module instruction_decode #(
  parameter int DATA_W = 64,
  parameter int REG_N  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_valid,
  input  logic [63:0]        if_pc,
  input  logic [31:0]        if_instr,
  input  logic               wb_we,
  input  logic [4:0]         wb_addr,
  input  logic [63:0]        wb_data,
  input  logic               flush,
  output logic               stall_out,
  output logic               id_valid,
  output logic [298:0]       id_buf
);

  localparam logic [4:0] XZR = 5'(REG_N - 1);

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;

  logic [DATA_W-1:0] regs [REG_N];

  logic [10:0]       op;
  logic [1:0]        alu_src, alu_op;
  logic              c_b, c_bz, c_bnz, c_mw, c_mr, c_m2r, c_rw;
  logic [DATA_W-1:0] imm;
  logic              rs2_is_rt, use_rs1, use_rs2;
  logic [4:0]        rs1, rs2, ex_rd;
  logic [DATA_W-1:0] rd1, rd2;
  logic              hazard;

  assign op = if_instr[31:21];

  always_comb begin
    alu_src   = 2'b00;
    alu_op    = 2'b00;
    c_b       = 1'b0;
    c_bz      = 1'b0;
    c_bnz     = 1'b0;
    c_mw      = 1'b0;
    c_mr      = 1'b0;
    c_m2r     = 1'b0;
    c_rw      = 1'b0;
    imm       = '0;
    rs2_is_rt = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) begin
      alu_op  = 2'b10;
      c_rw    = 1'b1;
      use_rs1 = 1'b1;
      use_rs2 = 1'b1;
    end else if (op == OP_LDUR) begin
      alu_src = 2'b01;
      c_mr    = 1'b1;
      c_m2r   = 1'b1;
      c_rw    = 1'b1;
      imm     = {{(DATA_W-9){if_instr[20]}}, if_instr[20:12]};
      use_rs1 = 1'b1;
    end else if (op == OP_STUR) begin
      alu_src   = 2'b01;
      c_mw      = 1'b1;
      imm       = {{(DATA_W-9){if_instr[20]}}, if_instr[20:12]};
      rs2_is_rt = 1'b1;
      use_rs1   = 1'b1;
      use_rs2   = 1'b1;
    end else if (if_instr[31:22] == OP_ADDI) begin
      alu_src = 2'b10;
      alu_op  = 2'b10;
      c_rw    = 1'b1;
      imm     = {{(DATA_W-12){1'b0}}, if_instr[21:10]};
      use_rs1 = 1'b1;
    end else if (if_instr[31:24] == OP_CBZ || if_instr[31:24] == OP_CBNZ) begin
      c_bz      = (if_instr[31:24] == OP_CBZ);
      c_bnz     = (if_instr[31:24] == OP_CBNZ);
      alu_op    = 2'b01;
      imm       = {{(DATA_W-19){if_instr[23]}}, if_instr[23:5]};
      rs2_is_rt = 1'b1;
      use_rs2   = 1'b1;
    end else if (if_instr[31:26] == OP_B) begin
      c_b = 1'b1;
      imm = {{(DATA_W-26){if_instr[25]}}, if_instr[25:0]};
    end
  end

  assign rs1 = if_instr[9:5];
  assign rs2 = rs2_is_rt ? if_instr[4:0] : if_instr[20:16];

  // Write-through lets WB and ID share a cycle without a forwarding path in EX.
  always_comb begin
    rd1 = regs[rs1];
    rd2 = regs[rs2];
    if (rs1 == XZR)                   rd1 = '0;
    else if (wb_we && wb_addr == rs1) rd1 = wb_data;
    if (rs2 == XZR)                   rd2 = '0;
    else if (wb_we && wb_addr == rs2) rd2 = wb_data;
  end

  assign ex_rd  = id_buf[68:64];
  assign hazard = id_valid && id_buf[296] && (ex_rd != XZR) && if_valid &&
                  ((use_rs1 && rs1 == ex_rd) || (use_rs2 && rs2 == ex_rd));
  assign stall_out = hazard && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (wb_we && wb_addr != XZR) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_buf   <= '0;
      id_valid <= 1'b0;
    end else if (!if_valid || flush || hazard) begin
      id_buf   <= '0;
      id_valid <= 1'b0;
    end else begin
      id_buf   <= {c_rw, c_m2r, c_mr, c_mw, c_bnz, c_bz, c_b, alu_op, alu_src,
                   rd2, rd1, imm, if_instr, if_pc};
      id_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Randomized + directed bench for instruction_decode against a mnemonic-level reference model.
module tb_instruction_decode;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         if_valid;
  logic [63:0]  if_pc;
  logic [31:0]  if_instr;
  logic         wb_we;
  logic [4:0]   wb_addr;
  logic [63:0]  wb_data;
  logic         flush;
  logic         stall_out;
  logic         id_valid;
  logic [298:0] id_buf;

  instruction_decode dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .stall_out(stall_out), .id_valid(id_valid), .id_buf(id_buf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [298:0] got, input logic [298:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [63:0]  m_regs [32];
  logic [298:0] m_buf;
  logic         m_valid;
  logic         m_stall;
  logic         obs_stall;

  localparam int K_NOP = 0, K_R = 1, K_LDUR = 2, K_STUR = 3, K_ADDI = 4,
                 K_CBZ = 5, K_CBNZ = 6, K_B = 7;

  function automatic int kind(input logic [31:0] ins);
    if (ins[31:21] inside {11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000})
      return K_R;
    if (ins[31:21] == 11'b11111000010) return K_LDUR;
    if (ins[31:21] == 11'b11111000000) return K_STUR;
    if (ins[31:22] == 10'b1001000100)  return K_ADDI;
    if (ins[31:24] == 8'hB4)           return K_CBZ;
    if (ins[31:24] == 8'hB5)           return K_CBNZ;
    if (ins[31:26] == 6'b000101)       return K_B;
    return K_NOP;
  endfunction

  function automatic logic [63:0] sext(input longint v, input int bits);
    longint r = v;
    if (r >= (longint'(1) <<< (bits - 1))) r = r - (longint'(1) <<< bits);
    return 64'(r);
  endfunction

  function automatic logic [63:0] rdreg(input logic [4:0] r, input logic we,
                                        input logic [4:0] wa, input logic [63:0] wd);
    if (r == 5'd31) return 64'd0;
    if (we && wa == r) return wd;
    return m_regs[r];
  endfunction

  function automatic bit uses(input logic [31:0] ins, input logic [4:0] r);
    case (kind(ins))
      K_R:            return (r == ins[9:5]) || (r == ins[20:16]);
      K_LDUR, K_ADDI: return r == ins[9:5];
      K_STUR:         return (r == ins[9:5]) || (r == ins[4:0]);
      K_CBZ, K_CBNZ:  return r == ins[4:0];
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [298:0] m_decode(input logic [31:0] ins, input logic [63:0] pc,
                                            input logic we, input logic [4:0] wa,
                                            input logic [63:0] wd);
    logic [1:0]  asrc = 0, aop = 0;
    logic        b = 0, bz = 0, bnz = 0, mw = 0, mr = 0, m2r = 0, rw = 0;
    logic [63:0] imm = 0;
    logic [4:0]  r2 = ins[20:16];
    case (kind(ins))
      K_R:    begin aop = 2; rw = 1; end
      K_LDUR: begin asrc = 1; mr = 1; m2r = 1; rw = 1; imm = sext(longint'(ins[20:12]), 9); end
      K_STUR: begin asrc = 1; mw = 1; imm = sext(longint'(ins[20:12]), 9); r2 = ins[4:0]; end
      K_ADDI: begin asrc = 2; aop = 2; rw = 1; imm = 64'(ins[21:10]); end
      K_CBZ:  begin bz = 1; aop = 1; imm = sext(longint'(ins[23:5]), 19); r2 = ins[4:0]; end
      K_CBNZ: begin bnz = 1; aop = 1; imm = sext(longint'(ins[23:5]), 19); r2 = ins[4:0]; end
      K_B:    begin b = 1; imm = sext(longint'(ins[25:0]), 26); end
      default: ;
    endcase
    return {rw, m2r, mr, mw, bnz, bz, b, aop, asrc,
            rdreg(r2, we, wa, wd), rdreg(ins[9:5], we, wa, wd), imm, ins, pc};
  endfunction

  // One cycle: drive after negedge, check stall, clock, check buffer, update model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                      input logic we, input logic [4:0] wa, input logic [63:0] wd,
                      input logic fl);
    logic [298:0] nb;
    logic         nv;
    bit           haz;
    if_valid = v; if_instr = ins; if_pc = pc;
    wb_we = we; wb_addr = wa; wb_data = wd; flush = fl;
    #1;
    haz = m_valid && m_buf[296] && (m_buf[68:64] != 5'd31) && v && uses(ins, m_buf[68:64]);
    m_stall = haz && !fl;
    obs_stall = stall_out;
    chk("stall_out", 299'(stall_out), 299'(m_stall));
    if (!v || fl || haz) begin nb = '0; nv = 1'b0; end
    else begin nb = m_decode(ins, pc, we, wa, wd); nv = 1'b1; end
    @(posedge clk);
    if (we && wa != 5'd31) m_regs[wa] = wd;
    m_buf = nb;
    m_valid = nv;
    #1;
    chk("id_valid", 299'(id_valid), 299'(m_valid));
    chk("id_buf", id_buf, m_buf);
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_buf = '0;
    m_valid = 1'b0;
    m_stall = 1'b0;
  endtask

  function automatic logic [4:0] rr();
    return ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [10:0] rops [4] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
    case ($urandom_range(0, 8))
      0:       return {rops[$urandom_range(0, 3)], rr(), 6'($urandom), rr(), rr()};
      1, 8:    return {11'b11111000010, 9'($urandom), 2'b00, rr(), rr()};
      2:       return {11'b11111000000, 9'($urandom), 2'b00, rr(), rr()};
      3:       return {10'b1001000100, 12'($urandom), rr(), rr()};
      4:       return {8'hB4, 19'($urandom), rr()};
      5:       return {8'hB5, 19'($urandom), rr()};
      6:       return {6'b000101, 26'($urandom)};
      default: return 32'($urandom);
    endcase
  endfunction

  logic [31:0] cur;

  initial begin
    rst_n = 1'b0; if_valid = 0; if_pc = 0; if_instr = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0; flush = 0;
    model_reset();
    #12;
    chk("rst_id_buf", id_buf, '0);
    chk("rst_id_valid", 299'(id_valid), '0);
    chk("rst_stall", 299'(stall_out), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD X3,X1,X2 after X1=5, X2=7
    step(0, 0, 0, 1, 5'd1, 64'd5, 0);
    step(0, 0, 0, 1, 5'd2, 64'd7, 0);
    step(1, 32'h8B020023, 64'h100, 0, 0, 0, 0);
    chk("add_rd1", 299'(id_buf[223:160]), 299'(5));
    chk("add_rd2", 299'(id_buf[287:224]), 299'(7));
    chk("add_aluop", 299'(id_buf[291:290]), 299'(2));
    chk("add_regwrite", 299'(id_buf[298]), 299'(1));

    // X31 write dropped, reads as zero
    step(0, 0, 0, 1, 5'd31, 64'hFF, 0);
    step(1, 32'h8B0203E3, 64'h104, 0, 0, 0, 0);
    chk("xzr_rd1", 299'(id_buf[223:160]), '0);

    // Write-through: WB X4=0xAB same cycle as read
    step(1, 32'h8B020083, 64'h108, 1, 5'd4, 64'hAB, 0);
    chk("wt_rd1", 299'(id_buf[223:160]), 299'(64'hAB));

    // LDUR X2,[X1,#8] then ADD X3,X2,X1: one stall, one bubble, then issue
    step(1, 32'hF8408022, 64'h10C, 0, 0, 0, 0);
    step(1, 32'h8B010043, 64'h110, 1, 5'd5, 64'h55, 0);
    chk("lu_stall", 299'(obs_stall), 299'(1));
    chk("lu_bubble", 299'(id_valid), '0);
    step(1, 32'h8B010043, 64'h110, 0, 0, 0, 0);
    chk("lu_nostall", 299'(obs_stall), '0);
    chk("lu_issue", 299'(id_valid), 299'(1));

    // Load to X31 never stalls
    step(1, 32'hF840803F, 64'h114, 0, 0, 0, 0);
    step(1, 32'h8B1F03E3, 64'h118, 0, 0, 0, 0);
    chk("xzr_ld_stall", 299'(obs_stall), '0);

    // CBZ imm19=-1, B imm26=0x10
    step(1, 32'hB4FFFFE0, 64'h11C, 0, 0, 0, 0);
    chk("cbz_imm", 299'(id_buf[159:96]), 299'(64'hFFFF_FFFF_FFFF_FFFF));
    chk("cbz_bz", 299'(id_buf[293]), 299'(1));
    step(1, 32'h14000010, 64'h120, 0, 0, 0, 0);
    chk("b_imm", 299'(id_buf[159:96]), 299'(64'h10));
    chk("b_b", 299'(id_buf[292]), 299'(1));

    // Flush together with a hazard
    step(1, 32'hF8408022, 64'h124, 0, 0, 0, 0);
    step(1, 32'h8B010043, 64'h128, 0, 0, 0, 1);
    chk("fl_stall", 299'(obs_stall), '0);
    chk("fl_bubble", 299'(id_valid), '0);

    // Async reset while stalling
    step(1, 32'hF8408022, 64'h12C, 0, 0, 0, 0);
    if_valid = 1; if_instr = 32'h8B010043; if_pc = 64'h130; flush = 0; wb_we = 0;
    #1;
    chk("ar_pre_stall", 299'(stall_out), 299'(1));
    rst_n = 1'b0;
    #1;
    chk("ar_stall", 299'(stall_out), '0);
    chk("ar_id_buf", id_buf, '0);
    chk("ar_id_valid", 299'(id_valid), '0);
    model_reset();
    if_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic; IF holds its instruction while stalled
    cur = rand_instr();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      ins = cur;
      step($urandom_range(0, 7) != 0, ins, 64'({$urandom, $urandom}),
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7) == 0 ? 31 : $urandom_range(0, 5)),
           64'({$urandom, $urandom}), $urandom_range(0, 11) == 0);
      if (!m_stall) cur = rand_instr();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
